// File: rtl/mux_sel_arbiter8.sv
// Round-robin arbiter for one shared 8:1 datapath mux: one-hot grant plus matching select,
// held until done, request drop, or the hold limit expires.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests starting after r_last
// BUSY  | grant held by requester r_sel; r_hold_cnt counts cycles held
module mux_sel_arbiter8 #(
    parameter int N_REQ    = 8,
    parameter int SEL_W    = 3,
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            r_state;
    logic [N_REQ-1:0]  r_grant;
    logic [SEL_W-1:0]  r_sel;
    logic              r_busy;
    logic              r_timeout;
    logic [SEL_W-1:0]  r_last;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [SEL_W-1:0]  w_pick;
    logic              w_owner_req;
    logic              w_at_limit;
    logic              w_release;

    // Scan from farthest to nearest so the nearest set bit after r_last wins.
    always_comb begin
        w_pick = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[SEL_W'((int'(r_last) + i) % N_REQ)]) begin
                w_pick = SEL_W'((int'(r_last) + i) % N_REQ);
            end
        end
    end

    assign w_owner_req = req[r_sel];
    assign w_at_limit  = (r_hold_cnt == HOLD_LIMIT);
    assign w_release   = done || !w_owner_req || w_at_limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_sel      <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_last     <= SEL_W'(N_REQ - 1);
            r_hold_cnt <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req != '0) begin
                        r_state    <= BUSY;
                        r_grant    <= N_REQ'(1) << w_pick;
                        r_sel      <= w_pick;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= HOLD_W'(1);
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_state    <= IDLE;
                        r_grant    <= '0;
                        r_sel      <= '0;
                        r_busy     <= 1'b0;
                        r_last     <= r_sel;
                        r_hold_cnt <= '0;
                        r_timeout  <= !done && w_owner_req && w_at_limit;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_mux_sel_arbiter8.sv
// Directed bench for mux_sel_arbiter8: reset, round-robin order, wrap, hold limit,
// request drop, non-preemption and asynchronous reset, plus per-cycle invariants.
module tb_mux_sel_arbiter8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;

    mux_sel_arbiter8 #(.N_REQ(8), .SEL_W(3), .MAX_HOLD(15)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Structural invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            vectors++;
            if (!$onehot0(grant)) begin
                miscompares++;
                $display("FAIL inv_onehot0 grant=%h", grant);
            end
            vectors++;
            if (busy !== (|grant)) begin
                miscompares++;
                $display("FAIL inv_busy busy=%b grant=%h", busy, grant);
            end
            vectors++;
            if (grant !== (busy ? (8'h01 << sel) : 8'h00)) begin
                miscompares++;
                $display("FAIL inv_grant_sel grant=%h sel=%0d busy=%b", grant, sel, busy);
            end
            vectors++;
            if (timeout && busy) begin
                miscompares++;
                $display("FAIL inv_timeout_busy timeout=%b busy=%b", timeout, busy);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        #3;
        vectors++;
        if ({grant, sel, busy, timeout} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_outputs grant=%h sel=%0d busy=%b timeout=%b want all 0",
                     grant, sel, busy, timeout);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req = 8'h01;
        tick();
        vectors++;
        if (grant !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant grant=%h sel=%0d busy=%b want 01/0/1", grant, sel, busy);
        end
        done = 1'b1;
        tick();
        vectors++;
        if (grant !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release grant=%h busy=%b want 00/0", grant, busy);
        end
        done = 1'b0;
        req  = 8'h00;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        req  = 8'hFF;
        done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            vectors++;
            if (grant !== (8'h01 << (k % 8)) || sel !== 3'(k % 8)) begin
                miscompares++;
                $display("FAIL rr_grant step=%0d grant=%h sel=%0d want %h/%0d",
                         k, grant, sel, 8'h01 << (k % 8), k % 8);
            end
            tick();
            vectors++;
            if (grant !== 8'h00 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_dead step=%0d grant=%h busy=%b want 00/0", k, grant, busy);
            end
        end
        req  = 8'h00;
        done = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h04;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h03;
        tick();
        vectors++;
        if (grant !== 8'h01 || sel !== 3'd0) begin
            miscompares++;
            $display("FAIL wrap_first grant=%h sel=%0d want 01/0", grant, sel);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        vectors++;
        if (grant !== 8'h02 || sel !== 3'd1) begin
            miscompares++;
            $display("FAIL wrap_second grant=%h sel=%0d want 02/1", grant, sel);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        int held;
        req  = 8'h10;
        done = 1'b0;
        held = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (grant === 8'h10 && timeout === 1'b0) held++;
        end
        vectors++;
        if (held != 15) begin
            miscompares++;
            $display("FAIL hold_cycles held=%0d want 15", held);
        end
        tick();
        vectors++;
        if (grant !== 8'h00 || timeout !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse grant=%h timeout=%b busy=%b want 00/1/0",
                     grant, timeout, busy);
        end
        tick();
        vectors++;
        if (grant !== 8'h10 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_regrant grant=%h timeout=%b want 10/0", grant, timeout);
        end
        // done coincident with the hold limit releases normally
        for (int c = 0; c < 14; c++) tick();
        vectors++;
        if (grant !== 8'h10) begin
            miscompares++;
            $display("FAIL limit_done_held grant=%h want 10", grant);
        end
        done = 1'b1;
        tick();
        vectors++;
        if (grant !== 8'h00 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL limit_done_release grant=%h timeout=%b want 00/0", grant, timeout);
        end
        done = 1'b0;
        req  = 8'h00;
        tick();
    endtask

    task automatic test_drop();
        req = 8'h20;
        tick();
        vectors++;
        if (grant !== 8'h20 || sel !== 3'd5) begin
            miscompares++;
            $display("FAIL drop_grant grant=%h sel=%0d want 20/5", grant, sel);
        end
        req = 8'h60;
        tick();
        vectors++;
        if (grant !== 8'h20) begin
            miscompares++;
            $display("FAIL no_preempt grant=%h want 20", grant);
        end
        req = 8'h40;
        tick();
        vectors++;
        if (grant !== 8'h00 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_release grant=%h timeout=%b want 00/0", grant, timeout);
        end
        tick();
        vectors++;
        if (grant !== 8'h40 || sel !== 3'd6) begin
            miscompares++;
            $display("FAIL drop_next grant=%h sel=%0d want 40/6", grant, sel);
        end
        // done with owner's request dropping: one release only
        done = 1'b1;
        req  = 8'h00;
        tick();
        done = 1'b0;
        tick();
        vectors++;
        if (grant !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_and_drop grant=%h busy=%b want 00/0", grant, busy);
        end
    endtask

    task automatic test_async_reset();
        req = 8'h08;
        tick();
        vectors++;
        if (grant !== 8'h08 || sel !== 3'd3) begin
            miscompares++;
            $display("FAIL async_pre grant=%h sel=%0d want 08/3", grant, sel);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (grant !== 8'h00 || busy !== 1'b0 || sel !== 3'd0) begin
            miscompares++;
            $display("FAIL async_reset grant=%h busy=%b sel=%0d want 00/0/0", grant, busy, sel);
        end
        req = 8'h81;
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (grant !== 8'h01 || sel !== 3'd0) begin
            miscompares++;
            $display("FAIL async_after grant=%h sel=%0d want 01/0", grant, sel);
        end
        req = 8'h00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
